// File: rtl/mc_resp_sram.sv
// mc_resp_sram: request responder backed by a local single-port SRAM of
// 2^MEM_AW 32-bit words. The request side (req_*) is answered with
// resp_ack/resp_nak/resp_rdata. The maintenance/refill side (ext_*) shares the
// SRAM port. A request that loses arbitration to ext is NAKed for retry. After
// a NAK the request side has priority, so ext cannot starve it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_addr_pre        word address, presented one cycle before req_valid
//   req_valid/req_write request strobe / direction (1 = write)
//   req_wdata/req_wmsk  write data / byte mask (1 = lane not written)
//   resp_ack/resp_nak   one-cycle completion / reject pulses
//   resp_rdata          read data, valid with resp_ack of a read
//   ext_addr/ext_wdata/ext_wmsk/ext_we/ext_valid  maintenance access
//   ext_ready           maintenance access granted this cycle
//   ext_rdata           maintenance read data, valid the cycle after grant
module mc_resp_sram #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr_pre,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wmsk,
    output logic                  resp_ack,
    output logic                  resp_nak,
    output logic [31:0]           resp_rdata,
    input  logic [MEM_AW-1:0]     ext_addr,
    input  logic [31:0]           ext_wdata,
    input  logic [3:0]            ext_wmsk,
    input  logic                  ext_we,
    input  logic                  ext_valid,
    output logic                  ext_ready,
    output logic [31:0]           ext_rdata
);

    typedef enum logic [1:0] {IDLE, RD_DATA, ACK} state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                prio_q, prio_d;
    logic                resp_ack_q, resp_ack_d;
    logic                resp_nak_q, resp_nak_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic [31:0]         rd_buf_q, rd_buf_d;
    logic [31:0]         ext_rdata_q, ext_rdata_d;

    logic                idle;
    logic                req_accept;
    logic                req_reject;
    logic                ext_grant;
    logic [MEM_AW-1:0]   port_addr;
    logic                port_we;
    logic [31:0]         port_wdata;
    logic [3:0]          port_wmsk;
    logic [31:0]         port_rdata;

    logic [31:0]         mem [0:(1<<MEM_AW)-1];

    // Upper request address bits are ignored: addresses alias modulo 2^MEM_AW.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^req_addr_pre[ADDR_WIDTH-1:MEM_AW];

    // Arbitration and SRAM port mux. Request and ext grants are mutually
    // exclusive, so the single port never sees two accesses in one cycle.
    always_comb begin
        idle       = (state_q == IDLE);
        req_accept = idle & req_valid & (~ext_valid | prio_q);
        req_reject = idle & req_valid & ext_valid & ~prio_q;
        ext_grant  = ext_valid & ~(idle & req_valid & prio_q);
        if (ext_grant) begin
            port_addr  = ext_addr;
            port_we    = ext_we;
            port_wdata = ext_wdata;
            port_wmsk  = ext_wmsk;
        end else begin
            port_addr  = addr_q;
            port_we    = req_accept & req_write;
            port_wdata = req_wdata;
            port_wmsk  = req_wmsk;
        end
        port_rdata = mem[port_addr];
    end

    always_ff @(posedge clk) begin
        if (port_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!port_wmsk[i]) begin
                    mem[port_addr][8*i +: 8] <= port_wdata[8*i +: 8];
                end
            end
        end
    end

    // Next state / outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = idle ? req_addr_pre[MEM_AW-1:0] : addr_q;
        prio_d       = prio_q;
        resp_ack_d   = 1'b0;
        resp_nak_d   = req_reject;
        resp_rdata_d = resp_rdata_q;
        rd_buf_d     = rd_buf_q;
        ext_rdata_d  = (ext_grant & ~ext_we) ? port_rdata : ext_rdata_q;

        if (req_reject) begin
            prio_d = 1'b1;
        end else if (req_accept) begin
            prio_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_accept) begin
                    if (req_write) begin
                        resp_ack_d = 1'b1;
                    end else begin
                        rd_buf_d = port_rdata;
                        state_d  = RD_DATA;
                    end
                end
            end
            RD_DATA: begin
                // resp_ack is registered, so it is set here to be high in ACK.
                resp_rdata_d = rd_buf_q;
                resp_ack_d   = 1'b1;
                state_d      = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            prio_q       <= 1'b0;
            resp_ack_q   <= 1'b0;
            resp_nak_q   <= 1'b0;
            resp_rdata_q <= '0;
            rd_buf_q     <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            prio_q       <= prio_d;
            resp_ack_q   <= resp_ack_d;
            resp_nak_q   <= resp_nak_d;
            resp_rdata_q <= resp_rdata_d;
            rd_buf_q     <= rd_buf_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign resp_ack   = resp_ack_q;
    assign resp_nak   = resp_nak_q;
    assign resp_rdata = resp_rdata_q;
    assign ext_ready  = ext_grant;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_mc_resp_sram.sv
// Testbench for mc_resp_sram: directed stimulus with a response scoreboard.
module tb_mc_resp_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] req_addr_pre = '0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmsk = '0;
    logic        resp_ack;
    logic        resp_nak;
    logic [31:0] resp_rdata;
    logic [9:0]  ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic [3:0]  ext_wmsk = '0;
    logic        ext_we = 1'b0;
    logic        ext_valid = 1'b0;
    logic        ext_ready;
    logic [31:0] ext_rdata;

    mc_resp_sram #(.ADDR_WIDTH(24), .MEM_AW(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr_pre(req_addr_pre), .req_valid(req_valid), .req_write(req_write),
        .req_wdata(req_wdata), .req_wmsk(req_wmsk),
        .resp_ack(resp_ack), .resp_nak(resp_nak), .resp_rdata(resp_rdata),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_wmsk(ext_wmsk),
        .ext_we(ext_we), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_nak;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input bit nak, input bit chk, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.is_nak = nak; e.chk_data = chk; e.data = d;
        q.push_back(e);
    endtask

    // Response monitor: every ack/nak must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("missed_resp_cycle", cyc, e.cyc);
            end
            if (resp_ack || resp_nak) begin
                check("ack_nak_exclusive", {31'b0, resp_ack & resp_nak}, 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_resp", {30'b0, resp_ack, resp_nak}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_is_nak", {31'b0, resp_nak}, {31'b0, e.is_nak});
                    if (e.chk_data) check("resp_rdata", resp_rdata, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_req(input logic [23:0] a, input logic [31:0] d, input logic [3:0] m);
        req_addr_pre = a;
        step();
        req_valid = 1'b1; req_write = 1'b1; req_wdata = d; req_wmsk = m;
        push(cyc + 1, 1'b0, 1'b0, '0);
        step();
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic read_req(input logic [23:0] a, input logic [31:0] d);
        req_addr_pre = a;
        step();
        req_valid = 1'b1; req_write = 1'b0;
        push(cyc + 2, 1'b0, 1'b1, d);
        step();
        req_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_ack", {31'b0, resp_ack}, 32'd0);
        check("rst_resp_nak", {31'b0, resp_nak}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_ext_rdata", ext_rdata, 32'd0);
        check("rst_ext_ready", {31'b0, ext_ready}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic write / read and byte masking.
        write_req(24'h000010, 32'hDEADBEEF, 4'b0000);
        read_req(24'h000010, 32'hDEADBEEF);
        write_req(24'h000010, 32'h11223344, 4'b1010);
        read_req(24'h000010, 32'hDE22BE44);

        // Strobe while in RD_DATA must be ignored (no response, no write).
        req_addr_pre = 24'h000010;
        step();
        req_valid = 1'b1; req_write = 1'b0;
        push(cyc + 2, 1'b0, 1'b1, 32'hDE22BE44);
        step();
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0; req_wmsk = 4'b0000;
        step();
        req_valid = 1'b0; req_write = 1'b0;
        step();

        // Conflict: ext wins first, then re-strobe on resp_nak wins via prio.
        req_addr_pre = 24'h000020;
        step();
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'hCAFEF00D; req_wmsk = 4'b0000;
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 10'h010;
        push(cyc + 1, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("conflict_ext_ready_t", {31'b0, ext_ready}, 32'd1);
        step();
        push(cyc + 1, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("restrobe_ext_ready", {31'b0, ext_ready}, 32'd0);
        check("conflict_ext_rdata", ext_rdata, 32'hDE22BE44);
        step();
        req_valid = 1'b0; req_write = 1'b0; ext_valid = 1'b0;
        read_req(24'h000020, 32'hCAFEF00D);

        // Aliasing across the upper address bits, and ext read of the same word.
        write_req(24'h000405, 32'h0BADC0DE, 4'b0000);
        read_req(24'h000005, 32'h0BADC0DE);
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 10'h005;
        @(negedge clk);
        check("alias_ext_ready", {31'b0, ext_ready}, 32'd1);
        step();
        ext_valid = 1'b0;
        @(negedge clk);
        check("alias_ext_rdata", ext_rdata, 32'h0BADC0DE);
        step();

        // Ext write, then request read of that word.
        ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 10'h007;
        ext_wdata = 32'h77AA55CC; ext_wmsk = 4'b0000;
        step();
        ext_valid = 1'b0; ext_we = 1'b0;
        read_req(24'h000007, 32'h77AA55CC);
        check("ext_rdata_hold_on_write", ext_rdata, 32'h0BADC0DE);

        // Back-to-back writes: strobes at T and T+1, acks at T+1 and T+2.
        req_addr_pre = 24'h000030;
        step();
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h30303030; req_wmsk = 4'b0000;
        push(cyc + 1, 1'b0, 1'b0, '0);
        req_addr_pre = 24'h000031;
        step();
        req_wdata = 32'h31313131;
        push(cyc + 1, 1'b0, 1'b0, '0);
        step();
        req_valid = 1'b0; req_write = 1'b0;
        read_req(24'h000030, 32'h30303030);
        read_req(24'h000031, 32'h31313131);

        // Reset asserted in the RD_DATA cycle aborts the read.
        req_addr_pre = 24'h000030;
        step();
        req_valid = 1'b1; req_write = 1'b0;
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrd_resp_ack", {31'b0, resp_ack}, 32'd0);
        check("midrd_resp_rdata", resp_rdata, 32'd0);
        check("midrd_ext_rdata", ext_rdata, 32'd0);
        step();
        check("midrd_resp_ack_hold", {31'b0, resp_ack}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_resp_rdata", resp_rdata, 32'd0);
        repeat (4) step();
        write_req(24'h000031, 32'h12345678, 4'b0000);
        read_req(24'h000031, 32'h12345678);

        repeat (5) step();
        check("scoreboard_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
